ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 3000, clock-low hold before start (120 us at 25 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, max app_clk cycles between device clock falling edges (2 ms at 25 MHz).
REQ-003 app_clk  input  1  sole clock, 25 MHz.
REQ-004 app_arst_n  input  1  asynchronous active-low reset.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request; byte accepted when tx_valid and tx_ready are both high.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk_in  input  1  raw PS2_CLK pin level.
REQ-009 ps2_data_in  input  1  raw PS2_DATA pin level.
REQ-010 ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release (open-collector).
REQ-011 ps2_data_oe  output  1  1 = pull PS2_DATA low; 0 = release.
REQ-012 tx_done  output  1  one-cycle pulse: frame acknowledged by device.
REQ-013 tx_err  output  1  one-cycle pulse: missing ACK or timeout.
REQ-014 busy  output  1  high in every state except IDLE; the receiver ignores the bus while busy.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; clock falling edge = synced value 1 then 0 on consecutive cycles.
REQ-016 States: IDLE, INHIBIT, START, BITS, ACK, RECOVER.
REQ-017 IDLE: both oe 0; on accept, latch tx_data, compute odd parity (parity = ~^tx_data), go INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; in the last cycle assert ps2_data_oe=1; then go START.
REQ-019 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); go BITS.
REQ-020 BITS: on device clock falling edges 1..8 drive data bits 0..7 LSB first (oe = ~bit); falling edge 9 drives parity; falling edge 10 releases data (stop bit 1); then go ACK.
REQ-021 ACK: on falling edge 11 sample synced data; 0 = ACK, go RECOVER with ack flag; 1 = go RECOVER with nack flag.
REQ-022 RECOVER: wait until synced clock and data both 1, then pulse tx_done (ack) or tx_err (nack) and return to IDLE.
REQ-023 A 16-bit timeout counter SHALL reset on each clock falling edge and on entering START; if it reaches TIMEOUT_CYCLES in START, BITS or ACK: release both lines, pulse tx_err, go IDLE.
REQ-024 Bit counter SHALL be 4 bits, 0..11, cleared on entering START.
REQ-025 tx_valid while busy SHALL be ignored; no queueing.
REQ-026 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-027 While app_arst_n=0: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0, tx_done=0, tx_err=0, busy=0, counters 0, synchronizers 1.
REQ-028 tx_ready SHALL rise the first cycle after reset release.
REQ-029 Reset mid-frame SHALL release both lines immediately (asynchronously); no done/err pulse.

Structure
REQ-030 State encodings, INHIBIT/TIMEOUT defaults and frame bit count (11) SHALL live in a shared ps2_defs package/include used by the receiver too.
REQ-031 One sub-module, ps2_sync_edge (2-flop sync + falling-edge detect), instantiated for clock and data; reusable by the receiver.
REQ-032 Top-level wiring: pin = oe ? 0 : Z, outside this block.

Verification
REQ-033 Send 0xED, device model clocks at 12.5 kHz and ACKs -> data bits on wire 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done one pulse; tx_err 0.
REQ-034 Send 0x00, device model leaves data high on the 11th clock -> parity 1, tx_err one pulse, tx_done 0.
REQ-035 Send 0xF4, device never clocks -> clock held low exactly 3000 cycles; tx_err exactly TIMEOUT_CYCLES cycles after START; both oe 0.
REQ-036 Assert tx_valid with 0x55 during the 0xED frame -> ignored; only 0xED bits appear on the wire.
REQ-037 Assert app_arst_n=0 after 5 data bits -> both oe 0 in the same cycle, no pulses; a 0xFF send after reset completes with tx_done.

Source files
------------

// File: rtl/ps2_defs.sv
//------------------------------------------------------------------------------
// ps2_defs
// Shared definitions for the PS/2 host transmitter and receiver: FSM state
// encodings, default timing constants (25 MHz app_clk25 domain) and the
// frame length.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_BITS    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } ps2_state_e;

  // 120 us clock-low hold before a host-to-device frame at 25 MHz.
  localparam int unsigned PS2_INHIBIT_CYCLES = 3000;
  // 2 ms maximum gap between device clock falling edges at 25 MHz.
  localparam int unsigned PS2_TIMEOUT_CYCLES = 50000;
  // start + 8 data + parity + stop/ack
  localparam int unsigned PS2_FRAME_BITS     = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
//------------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for a raw PS/2 pin plus falling-edge detection on
// the synchronized level. Flops reset to 1 (idle bus level).
//
// Ports:
//   app_clk     in   system clock
//   app_arst_n  in   asynchronous active-low reset
//   pin_in      in   raw pin level
//   level       out  synchronized pin level
//   fall        out  one-cycle pulse: synchronized level went 1 -> 0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_sync_edge (
  input  logic app_clk,
  input  logic app_arst_n,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic level_p2;

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      level_p2 <= 1'b1;
    end else begin
      // p0/p1: metastability chain
      sync_p0  <= pin_in;
      sync_p1  <= sync_p0;
      // p2: previous synchronized value for edge detection
      level_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = level_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Inhibits the bus by holding the
// clock low, presents the start bit, then shifts data bits LSB first,
// odd parity and stop on device clock falling edges, and checks the
// device ACK. Pins are open-collector: oe=1 pulls the line low.
//
// Ports:
//   app_clk      in   25 MHz system clock
//   app_arst_n   in   asynchronous active-low reset
//   tx_data      in   command byte
//   tx_valid     in   request; accepted when tx_valid && tx_ready
//   tx_ready     out  high only in IDLE
//   ps2_clk_in   in   raw PS2_CLK level
//   ps2_data_in  in   raw PS2_DATA level
//   ps2_clk_oe   out  1 = pull PS2_CLK low
//   ps2_data_oe  out  1 = pull PS2_DATA low
//   tx_done      out  one-cycle pulse: device acknowledged the frame
//   tx_err       out  one-cycle pulse: missing ACK or timeout
//   busy         out  high in every state except IDLE
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       app_clk,
  input  logic       app_arst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam logic [15:0] INH_LAST  = 16'(INHIBIT_CYCLES - 1);
  localparam logic [15:0] INH_DATA  = 16'(INHIBIT_CYCLES - 2);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  BIT_PAR   = 4'd8;
  localparam logic [3:0]  BIT_STOP  = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e  state;
  logic [15:0] tmo_cnt;
  logic [3:0]  bit_cnt;
  logic        ack_ok;
  logic [7:0]  tx_byte;
  logic        tx_par;

  logic clk_lvl;
  logic clk_fall;
  logic data_lvl;
  // The data line's falling edge plays no part in transmission.
  logic data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .app_clk    (app_clk),
    .app_arst_n (app_arst_n),
    .pin_in     (ps2_clk_in),
    .level      (clk_lvl),
    .fall       (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .app_clk    (app_clk),
    .app_arst_n (app_arst_n),
    .pin_in     (ps2_data_in),
    .level      (data_lvl),
    .fall       (data_fall_unused)
  );

  logic accept;
  assign accept = (state == ST_IDLE) && tx_valid && tx_ready;

  // Payload latch: data only, no reset needed.
  always_ff @(posedge app_clk) begin
    if (accept) begin
      tx_byte <= tx_data;
      tx_par  <= ps2_odd_parity(tx_data);
    end
  end

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= 16'd0;
      bit_cnt     <= 4'd0;
      ack_ok      <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (accept) begin
            state      <= ST_INHIBIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            tmo_cnt    <= 16'd0;
          end
        end

        ST_INHIBIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // Data goes low during the final cycle of the clock hold so the
          // start bit is already on the line when the clock is released.
          if (tmo_cnt == INH_DATA) ps2_data_oe <= 1'b1;
          if (tmo_cnt == INH_LAST) begin
            state       <= ST_START;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            tmo_cnt     <= 16'd0;
            bit_cnt     <= 4'd0;
          end
        end

        ST_START, ST_BITS, ST_ACK: begin
          if (clk_fall) tmo_cnt <= 16'd0;
          else          tmo_cnt <= tmo_cnt + 16'd1;

          if (!clk_fall && tmo_cnt == TMO_LAST) begin
            // Device stopped clocking: abandon the frame.
            state       <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            tx_err      <= 1'b1;
          end else if (state == ST_START) begin
            state <= ST_BITS;
          end else if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (state == ST_ACK) begin
              ack_ok <= ~data_lvl;
              state  <= ST_RECOVER;
            end else if (bit_cnt < BIT_PAR) begin
              ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
            end else if (bit_cnt == BIT_PAR) begin
              ps2_data_oe <= ~tx_par;
            end else if (bit_cnt == BIT_STOP) begin
              ps2_data_oe <= 1'b0;
              state       <= ST_ACK;
            end
          end
        end

        ST_RECOVER: begin
          if (clk_lvl && data_lvl) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            if (ack_ok) tx_done <= 1'b1;
            else        tx_err  <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 3000;
  localparam int TMO = 5000;

  logic       app_clk = 1'b0;
  logic       app_arst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  // Open-collector bus: either side may pull low.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .app_clk     (app_clk),
    .app_arst_n  (app_arst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .busy        (busy)
  );

  always #20 app_clk = ~app_clk;

  int cyc = 0;
  always @(posedge app_clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int oe_run = 0;
  int inh_len = 0;
  int start_cyc = 0;
  int err_cyc = 0;

  always @(negedge app_clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) oe_run <= oe_run + 1;
    else if (oe_run != 0) begin
      inh_len   <= oe_run;
      oe_run    <= 0;
      start_cyc <= cyc;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge app_clk);
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge app_clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Device-side clock generator: waits for the start condition, samples the
  // start bit, then issues n_falls clock pulses sampling data on each rise.
  task automatic device(input int half, input int n_falls, input bit ack,
                        output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < INH + 200) begin
      @(negedge app_clk);
      w++;
    end
    check("start_seen", (w < INH + 200), 1);
    repeat (half) @(negedge app_clk);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge app_clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_data_in;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
      repeat (half) @(negedge app_clk);
    end
  endtask

  task automatic wait_result(input int d0, input int e0);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
      @(negedge app_clk);
      w++;
    end
    repeat (5) @(negedge app_clk);
  endtask

  logic [10:0] bits;
  int d0, e0;

  initial begin
    // Reset state
    repeat (3) @(negedge app_clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    app_arst_n = 1'b1;
    @(negedge app_clk);
    check("ready_after_rst", tx_ready, 1);

    // 0xED with ACK, 0x55 offered while busy
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (100) @(negedge app_clk);
    check("ready_low_busy", tx_ready, 0);
    check("inhibit_clk_oe", ps2_clk_oe, 1);
    tx_valid = 1'b0;
    device(1000, 11, 1'b1, bits);
    wait_result(d0, e0);
    check("ed_bits", bits, 11'h7DA);
    check("ed_inhibit_len", inh_len, INH);
    check("ed_done", done_cnt - d0, 1);
    check("ed_err", err_cnt - e0, 0);
    repeat (20) @(negedge app_clk);
    check("ed_idle_ready", tx_ready, 1);
    check("ed_idle_busy", busy, 0);
    check("ed_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

    // 0x00, device does not ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    device(50, 11, 1'b0, bits);
    wait_result(d0, e0);
    check("nack_bits", bits, 11'h600);
    check("nack_err", err_cnt - e0, 1);
    check("nack_done", done_cnt - d0, 0);

    // 0xF4, device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    begin
      int w;
      w = 0;
      while (err_cnt == e0 && done_cnt == d0 && w < INH + TMO + 200) begin
        @(negedge app_clk);
        w++;
      end
    end
    repeat (2) @(negedge app_clk);
    check("tmo_inhibit_len", inh_len, INH);
    check("tmo_latency", err_cyc - start_cyc, TMO);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_ready", tx_ready, 1);

    // Reset after five data bits of 0x00
    send(8'h00);
    device(50, 5, 1'b1, bits);
    check("part_bits", bits[5:0], 0);
    check("part_data_oe", ps2_data_oe, 1);
    d0 = done_cnt; e0 = err_cnt;
    #5 app_arst_n = 1'b0;
    #1;
    check("arst_clk_oe", ps2_clk_oe, 0);
    check("arst_data_oe", ps2_data_oe, 0);
    check("arst_busy", busy, 0);
    repeat (3) @(negedge app_clk);
    app_arst_n = 1'b1;
    repeat (10) @(negedge app_clk);
    check("arst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // 0xFF after reset completes
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    device(50, 11, 1'b1, bits);
    wait_result(d0, e0);
    check("ff_bits", bits, 11'h7FE);
    check("ff_done", done_cnt - d0, 1);
    check("ff_err", err_cnt - e0, 0);
    check("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
